// File: rtl/frodo_stream_pkg.sv
// rtl/frodo_stream_pkg.sv - shared types and width defaults for the Frodo/Scloud stream blocks
//
// Purpose: common FSM state encoding for the FIFO unpack reader and the
//          default word/coefficient widths used across the stream datapath.
// Contents:
//   COEF_W          default coefficient (slice) width
//   WORD_W          default packed FIFO word width
//   unpack_state_e  IDLE / LOAD / EMIT / DONE states of fifo_unpack_reader
package frodo_stream_pkg;

  localparam int COEF_W = 16;
  localparam int WORD_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } unpack_state_e;

endpackage

// File: rtl/fifo_unpack_reader.sv
// rtl/fifo_unpack_reader.sv - drains packed FIFO words and streams their slices LSB first
//
// Purpose: per start command, pops IN_W-bit words from a first-word-fall-through
//          FIFO and emits num_slices OUT_W-bit slices on a valid/ready stream,
//          one slice per cycle when neither side stalls.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start, num_slices command strobe and slice count (sampled only in IDLE)
//   busy, done        busy during LOAD/EMIT; one-cycle done pulse after the last slice
//   fifo_empty        FIFO empty flag
//   fifo_dout         FIFO head word (valid whenever !fifo_empty)
//   fifo_pop          combinational pop, never asserted while fifo_empty
//   out_valid         slice valid
//   out_ready         downstream accept
//   out_data          current slice of the holding word
//   out_last          high with the final slice of the command
module fifo_unpack_reader
  import frodo_stream_pkg::*;
#(
  parameter int IN_W  = WORD_W,
  parameter int OUT_W = COEF_W,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] num_slices,
  output logic             busy,
  output logic             done,
  input  logic             fifo_empty,
  input  logic [IN_W-1:0]  fifo_dout,
  output logic             fifo_pop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);
  localparam logic [LEN_W-1:0] REM_ONE  = LEN_W'(1);

  unpack_state_e    state_q, state_d;
  logic [IN_W-1:0]  hreg_q, hreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             pop_raw;

  always_comb begin
    state_d = state_q;
    hreg_d  = hreg_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    pop_raw = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (num_slices == '0) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
            rem_d   = num_slices;
          end
        end
      end
      LOAD: begin
        if (!fifo_empty) begin
          pop_raw = 1'b1;
          hreg_d  = fifo_dout;
          idx_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          rem_d = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            // Remaining slices of the current word are dropped; no extra pop.
            state_d = DONE;
          end else if (idx_q != IDX_LAST) begin
            idx_d = idx_q + IDX_W'(1);
          end else if (!fifo_empty) begin
            // Reload in the same cycle as the last slice handshake: no bubble.
            pop_raw = 1'b1;
            hreg_d  = fifo_dout;
            idx_d   = '0;
          end else begin
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hreg_q  <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      hreg_q  <= hreg_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
    end
  end

  // Reset must win over a pending pop so the FIFO is not consumed in the reset cycle.
  assign fifo_pop  = pop_raw && !rst;
  assign busy      = (state_q == LOAD) || (state_q == EMIT);
  assign done      = (state_q == DONE);
  assign out_valid = (state_q == EMIT);
  assign out_last  = (state_q == EMIT) && (rem_q == REM_ONE);
  assign out_data  = hreg_q[idx_q*OUT_W +: OUT_W];

endmodule

// File: tb/tb_fifo_unpack_reader.sv
// tb/tb_fifo_unpack_reader.sv - directed self-checking bench for fifo_unpack_reader
module tb_fifo_unpack_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_slices;
  logic        busy;
  logic        done;
  logic        fifo_empty;
  logic [63:0] fifo_dout;
  logic        fifo_pop;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] W1 = 64'h4444_3333_2222_1111;
  localparam logic [63:0] W2 = 64'h8888_7777_6666_5555;

  // Simple FWFT FIFO model: push from the stimulus, pop on the DUT's request.
  logic [63:0] mem [0:15];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  int          pop_cnt = 0;
  int          pop_base;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_dout  = mem[rd_ptr[3:0]];

  always @(posedge clk) begin
    if (fifo_pop) begin
      rd_ptr  <= rd_ptr + 8'd1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  always #5 clk = ~clk;

  fifo_unpack_reader #(.IN_W(64), .OUT_W(16), .LEN_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_slices (num_slices),
    .busy       (busy),
    .done       (done),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_pop   (fifo_pop),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rdy);
    @(posedge clk);
    #1;
    out_ready = rdy;
    #1;
  endtask

  task automatic push(input logic [63:0] w);
    mem[wr_ptr[3:0]] = w;
    wr_ptr = wr_ptr + 8'd1;
    #1;
  endtask

  // start in the current cycle (cycle 0); returns in cycle 1
  task automatic start_cmd(input logic [15:0] n);
    start      = 1'b1;
    num_slices = n;
    step(out_ready);
    start = 1'b0;
  endtask

  task automatic exp_slice(input string tag, input logic [15:0] d, input logic l);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"}, 64'(out_data), 64'(d));
    chk({tag, "_last"}, 64'(out_last), 64'(l));
  endtask

  logic [15:0] s1 [0:3];
  logic [11:0] pat;
  int          e;
  int          k;

  initial begin
    s1[0] = 16'h1111; s1[1] = 16'h2222; s1[2] = 16'h3333; s1[3] = 16'h4444;
    pat = 12'b1010_1010_1001;  // bit k = out_ready in EMIT cycle k: 1,0,0,1,0,1,0,1,...
    rst = 1'b1; start = 1'b0; num_slices = 16'd0; out_ready = 1'b1;
    step(1'b1);
    step(1'b1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pop", 64'(fifo_pop), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    rst = 1'b0;
    step(1'b1);

    // 1: single word, 4 slices
    push(W1);
    pop_base = pop_cnt;
    start_cmd(16'd4);
    chk("t1_c1_pop", 64'(fifo_pop), 64'd1);
    chk("t1_c1_busy", 64'(busy), 64'd1);
    chk("t1_c1_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      exp_slice("t1_slice", s1[i], i == 3);
    end
    step(1'b1);
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_pops", 64'(pop_cnt - pop_base), 64'd1);
    step(1'b1);
    chk("t1_done_pulse", 64'(done), 64'd0);

    // 2: two words, 6 slices, reload with no bubble
    push(W1);
    push(W2);
    pop_base = pop_cnt;
    start_cmd(16'd6);
    chk("t2_c1_pop", 64'(fifo_pop), 64'd1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      exp_slice("t2_slice", 16'(i + 1) * 16'h1111, i == 5);
      chk("t2_pop_cycle", 64'(fifo_pop), 64'(i == 3));
    end
    step(1'b1);
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_pops", 64'(pop_cnt - pop_base), 64'd2);

    // 3: backpressure, outputs held while out_ready is low
    step(1'b1);
    push(W1);
    start_cmd(16'd4);
    step(pat[0]);
    e = 0;
    k = 0;
    while (e < 4 && k < 16) begin
      exp_slice("t3_slice", s1[e], e == 3);
      if (out_ready) e++;
      k++;
      if (e < 4) step(pat[k]);
    end
    chk("t3_all_slices", 64'(e), 64'd4);
    step(1'b1);
    chk("t3_done", 64'(done), 64'd1);

    // 4: FIFO empty at start, then stall in LOAD mid-transfer
    step(1'b1);
    pop_base = pop_cnt;
    start_cmd(16'd8);
    for (int i = 1; i <= 5; i++) begin
      chk("t4_wait_busy", 64'(busy), 64'd1);
      chk("t4_wait_valid", 64'(out_valid), 64'd0);
      chk("t4_wait_pop", 64'(fifo_pop), 64'd0);
      if (i < 5) step(1'b1);
    end
    push(W1);
    chk("t4_pop1", 64'(fifo_pop), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      exp_slice("t4_w1", s1[i], 1'b0);
      chk("t4_w1_nopop", 64'(fifo_pop), 64'd0);
    end
    step(1'b1);
    chk("t4_stall_busy", 64'(busy), 64'd1);
    chk("t4_stall_valid", 64'(out_valid), 64'd0);
    push(W2);
    chk("t4_pop2", 64'(fifo_pop), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      exp_slice("t4_w2", 16'(i + 5) * 16'h1111, i == 3);
    end
    step(1'b1);
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_pops", 64'(pop_cnt - pop_base), 64'd2);

    // 5: zero-length command, then start pulses ignored while busy
    step(1'b1);
    pop_base = pop_cnt;
    start_cmd(16'd0);
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_pop", 64'(fifo_pop), 64'd0);
    step(1'b1);
    chk("t5_done_pulse", 64'(done), 64'd0);
    chk("t5_pops0", 64'(pop_cnt - pop_base), 64'd0);
    push(W1);
    start_cmd(16'd2);
    start = 1'b1;
    num_slices = 16'd0;
    step(1'b1);
    exp_slice("t5_s0", 16'h1111, 1'b0);
    step(1'b1);
    exp_slice("t5_s1", 16'h2222, 1'b1);
    start = 1'b0;
    step(1'b1);
    chk("t5_done2", 64'(done), 64'd1);
    step(1'b1);
    chk("t5_idle_busy", 64'(busy), 64'd0);
    chk("t5_idle_done", 64'(done), 64'd0);

    // 6: reset mid-EMIT drops the partial word
    push(W1);
    push(W2);
    pop_base = pop_cnt;
    start_cmd(16'd4);
    step(1'b1);
    exp_slice("t6_s0", 16'h1111, 1'b0);
    step(1'b1);
    exp_slice("t6_s1", 16'h2222, 1'b0);
    step(1'b1);
    rst = 1'b1;
    #1;
    chk("t6_rst_pop", 64'(fifo_pop), 64'd0);
    step(1'b1);
    rst = 1'b0;
    #1;
    chk("t6_after_busy", 64'(busy), 64'd0);
    chk("t6_after_done", 64'(done), 64'd0);
    chk("t6_after_pop", 64'(fifo_pop), 64'd0);
    chk("t6_after_valid", 64'(out_valid), 64'd0);
    chk("t6_after_data", 64'(out_data), 64'd0);
    chk("t6_after_last", 64'(out_last), 64'd0);
    chk("t6_after_pops", 64'(pop_cnt - pop_base), 64'd1);
    start_cmd(16'd2);
    chk("t6_c1_pop", 64'(fifo_pop), 64'd1);
    step(1'b1);
    exp_slice("t6_n0", 16'h5555, 1'b0);
    step(1'b1);
    exp_slice("t6_n1", 16'h6666, 1'b1);
    step(1'b1);
    chk("t6_done", 64'(done), 64'd1);
    chk("t6_pops", 64'(pop_cnt - pop_base), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
